gray_ptr_ctrl: RTL and testbench

Parametrised Gray-coded FIFO pointer controller for one clock domain of an asynchronous FIFO. It generates a binary address for the local RAM port and a registered Gray pointer for the opposite domain's synchronizer. It also compares the local pointer with the remote pointer, already synchronized into this domain, to produce a registered full flag (write side) or empty flag (read side). Two instances, one per domain, plus two synchronizers form the pointer logic of an async FIFO.

---
 rtl/gray_ptr_ctrl_if.sv | 30 +++
 rtl/gray_ptr_ctrl.sv | 91 +++++++++
 tb/tb_gray_ptr_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_ctrl_if.sv
// Pointer-controller bus for one FIFO clock domain.
//   i_inc       : advance request (write or read strobe)
//   i_rptr_gray : remote Gray pointer, already synchronized into this domain
//   o_addr      : local RAM address
//   o_ptr_bin   : registered binary pointer
//   o_ptr_gray  : registered Gray pointer for the opposite domain
//   o_flag      : full (write side) or empty (read side)
//   o_almost    : almost-full / almost-empty
// master = the side issuing requests, slave = the pointer controller.
interface gray_ptr_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              i_inc;
  logic [ADDR_W:0]   i_rptr_gray;
  logic [ADDR_W-1:0] o_addr;
  logic [ADDR_W:0]   o_ptr_bin;
  logic [ADDR_W:0]   o_ptr_gray;
  logic              o_flag;
  logic              o_almost;

  modport master (
    output i_inc, i_rptr_gray,
    input  o_addr, o_ptr_bin, o_ptr_gray, o_flag, o_almost
  );

  modport slave (
    input  i_inc, i_rptr_gray,
    output o_addr, o_ptr_bin, o_ptr_gray, o_flag, o_almost
  );
endinterface

// File: rtl/gray_ptr_ctrl.sv
// Gray-coded FIFO pointer controller for one domain of an async FIFO.
// Produces the local RAM address, a flop-driven Gray pointer for the remote
// synchronizer, and a registered full (MODE 0) or empty (MODE 1) flag.
// Ports: i_clk (rising edge), i_rst (async, active-high), bus (slave modport
// of gray_ptr_ctrl_if carrying i_inc, i_rptr_gray and all o_* outputs).
// Optional macro GRAY_PTR_ALMOST_EN enables the almost-full/empty output;
// without it o_almost is tied low.
module gray_ptr_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned ALMOST_TH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  gray_ptr_ctrl_if.slave  bus
);

  localparam int unsigned PTR_W     = ADDR_W + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic        FLAG_RST  = (MODE != 0);

  logic             run_q;
  logic [PTR_W-1:0] ptr_bin_q,  ptr_bin_d;
  logic [PTR_W-1:0] ptr_gray_q, ptr_gray_d;
  logic             flag_q,     flag_d;
  logic             almost_q,   almost_d;
  logic             inc_ok;
  logic [PTR_W-1:0] full_cmp;

`ifdef GRAY_PTR_ALMOST_EN
  localparam logic  ALMOST_RST = (MODE != 0);
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_d;
`else
  localparam logic  ALMOST_RST = 1'b0;
`endif

  // Next pointer and flag; flag is evaluated on the post-increment pointer.
  always_comb begin
    // run_q blocks requests on the first edge after reset release
    inc_ok     = bus.i_inc & ~flag_q & run_q;
    ptr_bin_d  = ptr_bin_q + PTR_W'(inc_ok);
    ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
    // full: remote is exactly one lap behind (top two Gray bits inverted)
    full_cmp   = {~bus.i_rptr_gray[ADDR_W:ADDR_W-1], bus.i_rptr_gray[ADDR_W-2:0]};
    if (MODE == 0) flag_d = (ptr_gray_d == full_cmp);
    else           flag_d = (ptr_gray_d == bus.i_rptr_gray);
  end

`ifdef GRAY_PTR_ALMOST_EN
  // Remote Gray to binary: each bit is the XOR of all Gray bits above and at it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rbin[i] = ^(bus.i_rptr_gray >> i);
    end
    if (MODE == 0) level_d = ptr_bin_d - rbin;
    else           level_d = rbin - ptr_bin_d;
    if (MODE == 0) almost_d = (level_d >= PTR_W'(DEPTH - ALMOST_TH));
    else           almost_d = (level_d <= PTR_W'(ALMOST_TH));
  end
`else
  always_comb begin
    almost_d = 1'b0;
  end
`endif

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q      <= 1'b0;
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      flag_q     <= FLAG_RST;
      almost_q   <= ALMOST_RST;
    end else begin
      run_q      <= 1'b1;
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      flag_q     <= flag_d;
      almost_q   <= almost_d;
    end
  end

  assign bus.o_addr     = ptr_bin_q[ADDR_W-1:0];
  assign bus.o_ptr_bin  = ptr_bin_q;
  assign bus.o_ptr_gray = ptr_gray_q;
  assign bus.o_flag     = flag_q;
  assign bus.o_almost   = almost_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: one write-side and one read-side
// instance (ADDR_W=3) driven from vector tables plus hand-written sequences.
module tb_gray_ptr_ctrl;

`ifdef GRAY_PTR_ALMOST_EN
  localparam logic ALM_EN = 1'b1;
`else
  localparam logic ALM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl_if #(.ADDR_W(3)) if_wr ();
  gray_ptr_ctrl_if #(.ADDR_W(3)) if_rd ();

  gray_ptr_ctrl #(.ADDR_W(3), .MODE(0), .ALMOST_TH(2)) u_wr (
    .i_clk(clk), .i_rst(rst), .bus(if_wr.slave)
  );
  gray_ptr_ctrl #(.ADDR_W(3), .MODE(1), .ALMOST_TH(2)) u_rd (
    .i_clk(clk), .i_rst(rst), .bus(if_rd.slave)
  );

  typedef struct {
    logic       inc;
    logic [3:0] rptr;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       flag;
    logic       alm;
  } vec_t;

  vec_t wr_tab[12];
  vec_t rd_tab[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, release between edges, then burn the ignore edge.
  task automatic do_reset();
    rst = 1'b1;
    if_wr.i_inc = 1'b0; if_wr.i_rptr_gray = 4'h0;
    if_rd.i_inc = 1'b0; if_rd.i_rptr_gray = 4'h0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] prev_g;
    logic [3:0] exp_b;
    logic [3:0] diff;

    // write side: fill from empty, full, dropped request, release, refill
    wr_tab[0]  = '{1'b1, 4'h0, 4'h1, 4'b0001, 1'b0, 1'b0};
    wr_tab[1]  = '{1'b1, 4'h0, 4'h2, 4'b0011, 1'b0, 1'b0};
    wr_tab[2]  = '{1'b1, 4'h0, 4'h3, 4'b0010, 1'b0, 1'b0};
    wr_tab[3]  = '{1'b1, 4'h0, 4'h4, 4'b0110, 1'b0, 1'b0};
    wr_tab[4]  = '{1'b1, 4'h0, 4'h5, 4'b0111, 1'b0, 1'b0};
    wr_tab[5]  = '{1'b1, 4'h0, 4'h6, 4'b0101, 1'b0, 1'b1};
    wr_tab[6]  = '{1'b1, 4'h0, 4'h7, 4'b0100, 1'b0, 1'b1};
    wr_tab[7]  = '{1'b1, 4'h0, 4'h8, 4'b1100, 1'b1, 1'b1};
    wr_tab[8]  = '{1'b1, 4'h0, 4'h8, 4'b1100, 1'b1, 1'b1};
    wr_tab[9]  = '{1'b0, 4'b0001, 4'h8, 4'b1100, 1'b0, 1'b1};
    wr_tab[10] = '{1'b1, 4'b0001, 4'h9, 4'b1101, 1'b1, 1'b1};
    wr_tab[11] = '{1'b1, 4'b0001, 4'h9, 4'b1101, 1'b1, 1'b1};

    // read side: empty ignores reads, remote advance, drain to empty
    rd_tab[0] = '{1'b1, 4'b0000, 4'h0, 4'b0000, 1'b1, 1'b1};
    rd_tab[1] = '{1'b0, 4'b0011, 4'h0, 4'b0000, 1'b0, 1'b1};
    rd_tab[2] = '{1'b1, 4'b0011, 4'h1, 4'b0001, 1'b0, 1'b1};
    rd_tab[3] = '{1'b1, 4'b0011, 4'h2, 4'b0011, 1'b1, 1'b1};
    rd_tab[4] = '{1'b1, 4'b0011, 4'h2, 4'b0011, 1'b1, 1'b1};

    // reset values while reset is held
    rst = 1'b1;
    if_wr.i_inc = 1'b1; if_wr.i_rptr_gray = 4'h0;
    if_rd.i_inc = 1'b1; if_rd.i_rptr_gray = 4'h0;
    step();
    chk("rst wr bin",  32'(if_wr.o_ptr_bin),  32'h0);
    chk("rst wr gray", 32'(if_wr.o_ptr_gray), 32'h0);
    chk("rst wr addr", 32'(if_wr.o_addr),     32'h0);
    chk("rst wr flag", 32'(if_wr.o_flag),     32'h0);
    chk("rst wr alm",  32'(if_wr.o_almost),   32'h0);
    chk("rst rd bin",  32'(if_rd.o_ptr_bin),  32'h0);
    chk("rst rd gray", 32'(if_rd.o_ptr_gray), 32'h0);
    chk("rst rd flag", 32'(if_rd.o_flag),     32'h1);
    chk("rst rd alm",  32'(if_rd.o_almost),   32'(ALM_EN));

    // write-side table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if_wr.i_inc       = wr_tab[i].inc;
      if_wr.i_rptr_gray = wr_tab[i].rptr;
      step();
      chk($sformatf("wr[%0d] bin", i),  32'(if_wr.o_ptr_bin),  32'(wr_tab[i].bin));
      chk($sformatf("wr[%0d] gray", i), 32'(if_wr.o_ptr_gray), 32'(wr_tab[i].gray));
      chk($sformatf("wr[%0d] addr", i), 32'(if_wr.o_addr),     32'(wr_tab[i].bin[2:0]));
      chk($sformatf("wr[%0d] flag", i), 32'(if_wr.o_flag),     32'(wr_tab[i].flag));
      chk($sformatf("wr[%0d] alm", i),  32'(if_wr.o_almost),   32'(ALM_EN & wr_tab[i].alm));
    end

    // read-side table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if_rd.i_inc       = rd_tab[i].inc;
      if_rd.i_rptr_gray = rd_tab[i].rptr;
      step();
      chk($sformatf("rd[%0d] bin", i),  32'(if_rd.o_ptr_bin),  32'(rd_tab[i].bin));
      chk($sformatf("rd[%0d] gray", i), 32'(if_rd.o_ptr_gray), 32'(rd_tab[i].gray));
      chk($sformatf("rd[%0d] flag", i), 32'(if_rd.o_flag),     32'(rd_tab[i].flag));
      chk($sformatf("rd[%0d] alm", i),  32'(if_rd.o_almost),   32'(ALM_EN & rd_tab[i].alm));
    end

    // read-side wrap with remote staying ahead of the local pointer
    do_reset();
    if_rd.i_inc = 1'b0;
    if_rd.i_rptr_gray = to_gray(4'h1);
    step();
    chk("wrap pre flag", 32'(if_rd.o_flag), 32'h0);
    prev_g = if_rd.o_ptr_gray;
    for (int k = 0; k < 16; k++) begin
      if_rd.i_inc = 1'b1;
      if_rd.i_rptr_gray = to_gray(4'(k + 2));
      step();
      exp_b = 4'(k + 1);
      diff  = prev_g ^ if_rd.o_ptr_gray;
      chk($sformatf("wrap[%0d] bin", k),  32'(if_rd.o_ptr_bin),  32'(exp_b));
      chk($sformatf("wrap[%0d] gray", k), 32'(if_rd.o_ptr_gray), 32'(to_gray(exp_b)));
      chk($sformatf("wrap[%0d] 1bit", k), 32'($countones(diff)), 32'h1);
      prev_g = if_rd.o_ptr_gray;
    end
    chk("wrap end gray", 32'(if_rd.o_ptr_gray), 32'h0);
    if_rd.i_inc = 1'b0;

    // async reset mid-stream on the write side
    do_reset();
    if_wr.i_rptr_gray = 4'h0;
    if_wr.i_inc = 1'b1;
    repeat (5) step();
    chk("mid pre bin", 32'(if_wr.o_ptr_bin), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst bin",  32'(if_wr.o_ptr_bin),  32'h0);
    chk("mid rst gray", 32'(if_wr.o_ptr_gray), 32'h0);
    chk("mid rst addr", 32'(if_wr.o_addr),     32'h0);
    chk("mid rst flag", 32'(if_wr.o_flag),     32'h0);
    chk("mid rst alm",  32'(if_wr.o_almost),   32'h0);
    rst = 1'b0;
    step();
    chk("mid first edge bin", 32'(if_wr.o_ptr_bin), 32'h0);
    step();
    chk("mid second edge bin", 32'(if_wr.o_ptr_bin), 32'h1);
    if_wr.i_inc = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
